// File: rtl/apb_i2c_regif.sv
// APB register file, TX/RX FIFOs and masked interrupt for the I2C core.
// Optional pslverr reporting: define APB_I2C_REGIF_PSLVERR_EN.
module apb_i2c_regif #(
  parameter int DATA_W    = 8,
  parameter int TX_DEPTH  = 8,
  parameter int RX_DEPTH  = 8,
  parameter int TX_THRESH = 2,
  parameter int RX_THRESH = 6
) (
  input  logic              pclk,
  input  logic              n_rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              tx_rd_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_empty,
  input  logic              rx_wr_en,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_full,
  input  logic [5:0]        i2c_status,
  output logic [10:0]       control,
  output logic [9:0]        address,
  output logic [31:0]       clk_div,
  output logic              i2c_interrupt
);
  localparam int TPW = $clog2(TX_DEPTH);
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int TCW = $clog2(TX_DEPTH + 1);
  localparam int RCW = $clog2(RX_DEPTH + 1);

  logic              acc, wr, rd;
  logic [2:0]        sel;
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TPW-1:0]    tx_wp, tx_rp;
  logic [RPW-1:0]    rx_wp, rx_rp;
  logic [TCW-1:0]    tx_cnt;
  logic [RCW-1:0]    rx_cnt;
  logic              tx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              tx_push_req, rx_pop_req, tx_flush;
  logic [12:6]       sticky, set_ev, clr;
  logic [12:0]       status;
  logic [12:0]       irq_en;
  logic [DATA_W-1:0] rx_head;
  logic              unused;

  assign acc = psel & penable;
  assign wr  = acc & pwrite;
  assign rd  = acc & ~pwrite;
  assign sel = paddr[4:2];
  assign pready = 1'b1;
  assign unused = ^{paddr[31:5], paddr[1:0]};

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == TCW'(TX_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RCW'(RX_DEPTH));

  assign tx_flush    = i2c_status[0] | i2c_status[3];
  assign tx_push_req = wr & (sel == 3'd5);
  assign rx_pop_req  = rd & (sel == 3'd6);
  assign tx_pop  = tx_rd_en & ~tx_empty;
  assign tx_push = tx_push_req & (~tx_full | tx_pop) & ~tx_flush;
  assign rx_pop  = rx_pop_req & ~rx_empty;
  assign rx_push = rx_wr_en & (~rx_full | rx_pop);

  assign tx_data = tx_empty ? '0 : tx_mem[tx_rp];
  assign rx_head = rx_empty ? '0 : rx_mem[rx_rp];

  assign set_ev = {i2c_status[4:1],
                   (tx_rd_en & tx_empty) | (rx_pop_req & rx_empty),
                   rx_wr_en & rx_full & ~rx_pop,
                   tx_push_req & tx_full & ~tx_pop};
  assign clr = (wr && sel == 3'd3) ? pwdata[12:6] : '0;

  assign status = {sticky,
                   rx_cnt >= RCW'(RX_THRESH),
                   tx_cnt <= TCW'(TX_THRESH),
                   rx_full, rx_empty, tx_full, tx_empty};

  always_ff @(posedge pclk) begin
    if (tx_push) tx_mem[tx_wp] <= pwdata[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push)
        tx_wp <= (tx_wp == TPW'(TX_DEPTH - 1)) ? '0 : tx_wp + TPW'(1);
      if (tx_pop)
        tx_rp <= (tx_rp == TPW'(TX_DEPTH - 1)) ? '0 : tx_rp + TPW'(1);
      tx_cnt <= tx_cnt + TCW'(tx_push) - TCW'(tx_pop);
    end
  end

  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push)
        rx_wp <= (rx_wp == RPW'(RX_DEPTH - 1)) ? '0 : rx_wp + RPW'(1);
      if (rx_pop)
        rx_rp <= (rx_rp == RPW'(RX_DEPTH - 1)) ? '0 : rx_rp + RPW'(1);
      rx_cnt <= rx_cnt + RCW'(rx_push) - RCW'(rx_pop);
    end
  end

  // Core-driven clear of CTRL has priority over a bus write.
  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      control       <= '0;
      address       <= '0;
      clk_div       <= '0;
      irq_en        <= '0;
      sticky        <= '0;
      i2c_interrupt <= 1'b0;
    end else begin
      if (i2c_status[5])
        control <= '0;
      else if (wr && sel == 3'd0)
        control <= pwdata[10:0];
      if (wr && sel == 3'd1) address <= pwdata[9:0];
      if (wr && sel == 3'd2) clk_div <= pwdata;
      if (wr && sel == 3'd4) irq_en  <= pwdata[12:0];
      sticky        <= (sticky & ~clr) | set_ev;
      i2c_interrupt <= |(status & irq_en);
    end
  end

  always_comb begin
    prdata = '0;
    case (sel)
      3'd0:    prdata = 32'(control);
      3'd1:    prdata = 32'(address);
      3'd2:    prdata = clk_div;
      3'd3:    prdata = 32'(status);
      3'd4:    prdata = 32'(irq_en);
      3'd6:    prdata = 32'(rx_head);
      3'd7:    prdata = {16'(rx_cnt), 16'(tx_cnt)};
      default: prdata = '0;
    endcase
  end

`ifdef APB_I2C_REGIF_PSLVERR_EN
  assign pslverr = acc & (
    (pwrite & ((sel == 3'd3 && (|pwdata[31:13] || |pwdata[5:0])) ||
               sel == 3'd6 || sel == 3'd7 ||
               (sel == 3'd5 && tx_full))) |
    (~pwrite & (sel == 3'd5 || (sel == 3'd6 && rx_empty))));
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_i2c_regif.sv
// Self-checking bench for apb_i2c_regif with scoreboard queues for both FIFOs.
module tb_apb_i2c_regif;
  logic        pclk = 1'b0;
  logic        n_rst = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        tx_rd_en = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_empty;
  logic        rx_wr_en = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_full;
  logic [5:0]  i2c_status = '0;
  logic [10:0] control;
  logic [9:0]  address;
  logic [31:0] clk_div;
  logic        i2c_interrupt;

  int errors = 0;
  int checks = 0;
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [31:0] rdat;
  logic        rerr;
  logic [7:0]  exp8;
`ifdef APB_I2C_REGIF_PSLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  always #5 pclk = ~pclk;

  apb_i2c_regif dut (
    .pclk(pclk), .n_rst(n_rst),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr),
    .tx_rd_en(tx_rd_en), .tx_data(tx_data), .tx_empty(tx_empty),
    .rx_wr_en(rx_wr_en), .rx_data(rx_data), .rx_full(rx_full),
    .i2c_status(i2c_status), .control(control), .address(address),
    .clk_div(clk_div), .i2c_interrupt(i2c_interrupt)
  );

  // Starts and ends at a falling edge; side inputs live only in the access phase.
  task automatic apb_xfer(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [5:0] st,
                          input logic rxw, input logic [7:0] rxd,
                          output logic [31:0] rv, output logic ev);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1; i2c_status = st; rx_wr_en = rxw; rx_data = rxd;
    #1;
    rv = prdata; ev = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    i2c_status = '0; rx_wr_en = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rv; logic ev;
    apb_xfer(1'b1, a, d, 6'd0, 1'b0, 8'd0, rv, ev);
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] rv,
                        output logic ev);
    apb_xfer(1'b0, a, 32'd0, 6'd0, 1'b0, 8'd0, rv, ev);
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    repeat (3) @(negedge pclk);
    n_rst = 1'b1;
    @(negedge pclk);
    checks++;
    if (i2c_interrupt !== 1'b0 || tx_empty !== 1'b1 || rx_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins irq=%b tx_empty=%b rx_full=%b want 0 1 0",
               i2c_interrupt, tx_empty, rx_full);
    end
    apb_rd(32'h0C, rdat, rerr);
    checks++;
    if (rdat !== 32'h15 || rerr !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got %h err=%b want 00000015 err=0", rdat, rerr);
    end
    apb_rd(32'h1C, rdat, rerr);
    checks++;
    if (rdat !== 32'h0) begin
      errors++;
      $display("FAIL reset_level got %h want 00000000", rdat);
    end
  endtask

  task automatic test_regs;
    apb_wr(32'h04, 32'hFFFF_FFFF);
    apb_wr(32'h08, 32'hDEAD_BEEF);
    apb_wr(32'h10, 32'hFFFF_FFFF);
    apb_rd(32'h04, rdat, rerr);
    checks++;
    if (rdat !== 32'h3FF || address !== 10'h3FF) begin
      errors++;
      $display("FAIL addr_reg got %h pin %h want 000003ff", rdat, address);
    end
    apb_rd(32'h08, rdat, rerr);
    checks++;
    if (rdat !== 32'hDEAD_BEEF || clk_div !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL clkdiv got %h pin %h want deadbeef", rdat, clk_div);
    end
    apb_rd(32'h10, rdat, rerr);
    checks++;
    if (rdat !== 32'h1FFF) begin
      errors++;
      $display("FAIL irq_en got %h want 00001fff", rdat);
    end
    apb_wr(32'h10, 32'h0);
    apb_rd(32'h14, rdat, rerr);
    checks++;
    if (rdat !== 32'h0 || rerr !== ERR_EN) begin
      errors++;
      $display("FAIL txdata_read got %h err=%b want 0 err=%b", rdat, rerr, ERR_EN);
    end
  endtask

  task automatic test_tx_fwft;
    txq.push_back(8'hA5); apb_wr(32'h14, 32'hA5);
    txq.push_back(8'h3C); apb_wr(32'h14, 32'h3C);
    apb_rd(32'h1C, rdat, rerr);
    checks++;
    if (rdat !== 32'h0000_0002) begin
      errors++;
      $display("FAIL tx_level got %h want 00000002", rdat);
    end
    while (txq.size() > 0) begin
      exp8 = txq.pop_front();
      checks++;
      if (tx_data !== exp8) begin
        errors++;
        $display("FAIL tx_head got %h want %h", tx_data, exp8);
      end
      tx_rd_en = 1'b1;
      @(negedge pclk);
      tx_rd_en = 1'b0;
    end
    checks++;
    if (tx_empty !== 1'b1) begin
      errors++;
      $display("FAIL tx_drained tx_empty=%b want 1", tx_empty);
    end
  endtask

  task automatic test_tx_overflow;
    for (int i = 0; i < 8; i++) begin
      exp8 = 8'($urandom_range(0, 255));
      txq.push_back(exp8);
      apb_wr(32'h14, 32'(exp8));
    end
    apb_rd(32'h0C, rdat, rerr);
    checks++;
    if (rdat !== 32'h06) begin
      errors++;
      $display("FAIL tx_full_status got %h want 00000006", rdat);
    end
    apb_xfer(1'b1, 32'h14, 32'hEE, 6'd0, 1'b0, 8'd0, rdat, rerr);
    checks++;
    if (rerr !== ERR_EN) begin
      errors++;
      $display("FAIL tx_push_full_err got %b want %b", rerr, ERR_EN);
    end
    apb_rd(32'h0C, rdat, rerr);
    checks++;
    if (rdat !== 32'h46) begin
      errors++;
      $display("FAIL tx_ovf_status got %h want 00000046", rdat);
    end
    apb_wr(32'h10, 32'h40);
    checks++;
    if (i2c_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL irq_latency got %b want 0", i2c_interrupt);
    end
    @(negedge pclk);
    checks++;
    if (i2c_interrupt !== 1'b1) begin
      errors++;
      $display("FAIL irq_set got %b want 1", i2c_interrupt);
    end
    apb_wr(32'h0C, 32'h40);
    @(negedge pclk);
    checks++;
    if (i2c_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear got %b want 0", i2c_interrupt);
    end
    apb_wr(32'h10, 32'h0);
    while (txq.size() > 0) begin
      exp8 = txq.pop_front();
      checks++;
      if (tx_data !== exp8) begin
        errors++;
        $display("FAIL tx_drain got %h want %h", tx_data, exp8);
      end
      tx_rd_en = 1'b1;
      @(negedge pclk);
      tx_rd_en = 1'b0;
    end
    apb_wr(32'h0C, 32'h3F);
    apb_rd(32'h0C, rdat, rerr);
    checks++;
    if (rdat !== 32'h15) begin
      errors++;
      $display("FAIL live_w1c got %h want 00000015", rdat);
    end
  endtask

  task automatic test_rx_full_simul;
    for (int i = 0; i < 8; i++) begin
      exp8 = 8'(8'h10 + i);
      rxq.push_back(exp8);
      rx_wr_en = 1'b1; rx_data = exp8;
      @(negedge pclk);
      rx_wr_en = 1'b0;
    end
    apb_rd(32'h0C, rdat, rerr);
    checks++;
    if (rdat !== 32'h39 || rx_full !== 1'b1) begin
      errors++;
      $display("FAIL rx_full_status got %h pin %b want 00000039 1", rdat, rx_full);
    end
    apb_xfer(1'b0, 32'h18, 32'd0, 6'd0, 1'b1, 8'h77, rdat, rerr);
    exp8 = rxq.pop_front();
    rxq.push_back(8'h77);
    checks++;
    if (rdat !== 32'(exp8)) begin
      errors++;
      $display("FAIL rx_simul_head got %h want %h", rdat, exp8);
    end
    apb_rd(32'h1C, rdat, rerr);
    checks++;
    if (rdat !== 32'h0008_0000) begin
      errors++;
      $display("FAIL rx_simul_level got %h want 00080000", rdat);
    end
    apb_rd(32'h0C, rdat, rerr);
    checks++;
    if (rdat[7] !== 1'b0) begin
      errors++;
      $display("FAIL rx_no_ovf got %b want 0", rdat[7]);
    end
    while (rxq.size() > 0) begin
      apb_rd(32'h18, rdat, rerr);
      exp8 = rxq.pop_front();
      checks++;
      if (rdat !== 32'(exp8) || rerr !== 1'b0) begin
        errors++;
        $display("FAIL rx_drain got %h err=%b want %h err=0", rdat, rerr, exp8);
      end
    end
    apb_rd(32'h18, rdat, rerr);
    checks++;
    if (rdat !== 32'h0 || rerr !== ERR_EN) begin
      errors++;
      $display("FAIL rx_underrun_read got %h err=%b want 0 err=%b", rdat, rerr, ERR_EN);
    end
    apb_rd(32'h0C, rdat, rerr);
    checks++;
    if (rdat !== 32'h115) begin
      errors++;
      $display("FAIL rx_underrun_status got %h want 00000115", rdat);
    end
    apb_wr(32'h0C, 32'h100);
  endtask

  task automatic test_flush_ctrl;
    apb_wr(32'h00, 32'h7FF);
    checks++;
    if (control !== 11'h7FF) begin
      errors++;
      $display("FAIL ctrl_write got %h want 7ff", control);
    end
    apb_xfer(1'b1, 32'h00, 32'h7FF, 6'h20, 1'b0, 8'd0, rdat, rerr);
    checks++;
    if (control !== 11'h0) begin
      errors++;
      $display("FAIL ctrl_clear got %h want 000", control);
    end
    for (int i = 0; i < 3; i++) apb_wr(32'h14, 32'(i + 1));
    apb_xfer(1'b1, 32'h14, 32'h99, 6'h08, 1'b0, 8'd0, rdat, rerr);
    apb_rd(32'h1C, rdat, rerr);
    checks++;
    if (rdat !== 32'h0 || tx_empty !== 1'b1) begin
      errors++;
      $display("FAIL tx_flush got %h empty=%b want 00000000 1", rdat, tx_empty);
    end
    apb_rd(32'h0C, rdat, rerr);
    checks++;
    if (rdat !== 32'h815) begin
      errors++;
      $display("FAIL event_sticky got %h want 00000815", rdat);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_fwft();
    test_tx_overflow();
    test_rx_full_simul();
    test_flush_ctrl();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
